bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/bcd_digit.sv | 42 ++++
 rtl/bcd_scan_counter.sv | 109 ++++++++++
 tb/tb_bcd_scan_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared BCD digit type and 7-segment encoding used by the BCD scan counter.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Segments are {dp,g,f,e,d,c,b,a}, active-high; dp is never lit.
    function automatic logic [7:0] seg7_encode(input bcd_t d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal counting cell; chained through step_in/step_out to form a multi-digit counter.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic clk,
    input  logic rst_syn,
    input  logic step_in,
    input  logic up,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t digit,
    output logic step_out
);

    bcd_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = (load_val > BCD_MAX) ? BCD_MAX : load_val;
        end else if (step_in) begin
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_syn) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    // Carry on 9->0 when counting up, borrow on 0->9 when counting down.
    assign step_out = step_in & (up ? (digit_q == BCD_MAX) : (digit_q == 4'd0));

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with multiplexed 7-segment scan output.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero one.
module bcd_scan_counter
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_syn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_t              digits [DIGITS];
    logic [DIGITS:0]   step;
    logic              wrap_q;
    logic [DivW-1:0]   div_q;
    logic [IdxW-1:0]   idx_q;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    // Load overrides counting, so the chain never steps on a load cycle.
    assign step[0] = en & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_syn  (rst_syn),
            .step_in  (step[i]),
            .up       (up),
            .load     (load),
            .load_val (load_val[4*i +: 4]),
            .digit    (digits[i]),
            .step_out (step[i+1])
        );
        assign count[4*i +: 4] = digits[i];
    end

    always_ff @(posedge clk) begin
        if (rst_syn) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= step[DIGITS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_syn) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DivW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              lead;

    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead & (digits[i] == 4'd0);
            blank[i] = lead;
        end
    end
`endif

    always_comb begin
        an_d        = '0;
        an_d[idx_q] = 1'b1;
        seg_d       = seg7_encode(digits[idx_q]);
`ifdef LEADING_ZERO_BLANK_EN
        if (blank[idx_q]) begin
            seg_d = 8'h00;
        end
`endif
    end

    // an and seg are registered together so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst_syn) begin
            an_q  <= DIGITS'(1);
            seg_q <= 8'h3F;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign wrap = wrap_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed self-checking bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4).
// Define LEADING_ZERO_BLANK_EN to check the blanking variant.
module tb_bcd_scan_counter;

    logic        clk = 1'b0;
    logic        rst_syn = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic        wrap;
    logic [7:0]  seg;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_scan_counter #(
        .DIGITS   (4),
        .SCAN_DIV (4)
    ) dut (
        .clk      (clk),
        .rst_syn  (rst_syn),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .seg      (seg),
        .an       (an)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_syn = 1'b1;
        step();
        rst_syn = 1'b0;
        n_tests++;
        if (count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_count: got %h expected 0000", count);
        end
        n_tests++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wrap: got %b expected 0", wrap);
        end
        n_tests++;
        if (an !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_an: got %b expected 0001", an);
        end
        n_tests++;
        if (seg !== 8'h3F) begin
            n_fail++;
            $display("FAIL reset_seg: got %h expected 3F", seg);
        end
    endtask

    task automatic test_carry();
        logic [15:0] exp_c [3] = '{16'h0099, 16'h0100, 16'h0101};
        load_val = 16'h0099;
        load     = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (count !== exp_c[k] || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL carry_%0d: got %h/%b expected %h/0", k, count, wrap, exp_c[k]);
            end
            if (k < 2) begin
                en = 1'b1;
                up = 1'b1;
                step();
            end
        end
        en = 1'b0;
        step();
        n_tests++;
        if (count !== 16'h0101 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got %h/%b expected 0101/0", count, wrap);
        end
    endtask

    task automatic test_wrap();
        load_val = 16'h9999;
        load     = 1'b1;
        step();
        load = 1'b0;
        n_tests++;
        if (count !== 16'h9999 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_load: got %h/%b expected 9999/0", count, wrap);
        end
        en = 1'b1;
        up = 1'b1;
        step();
        n_tests++;
        if (count !== 16'h0000 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: got %h/%b expected 0000/1", count, wrap);
        end
        up = 1'b0;
        step();
        n_tests++;
        if (count !== 16'h9999 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_down: got %h/%b expected 9999/1", count, wrap);
        end
        step();
        n_tests++;
        if (count !== 16'h9998 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL after_wrap: got %h/%b expected 9998/0", count, wrap);
        end
        en = 1'b0;
        up = 1'b1;
        step();
        n_tests++;
        if (count !== 16'h9998 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_hold: got %h/%b expected 9998/0", count, wrap);
        end
    endtask

    task automatic test_load_priority();
        load_val = 16'h00AF;
        load     = 1'b1;
        en       = 1'b1;
        up       = 1'b1;
        step();
        load = 1'b0;
        en   = 1'b0;
        n_tests++;
        if (count !== 16'h0099 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp: got %h/%b expected 0099/0", count, wrap);
        end
    endtask

    // Reset then 17 further edges puts the scan at the start of an an=0001 window.
    task automatic test_scan();
        logic [7:0] exp_seg [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        logic [3:0] exp_an;
        rst_syn = 1'b1;
        step();
        rst_syn  = 1'b0;
        load_val = 16'h1234;
        load     = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 16; k++) step();
        for (int k = 0; k < 16; k++) begin
            exp_an = 4'b0001 << (k / 4);
            n_tests++;
            if (an !== exp_an || seg !== exp_seg[k/4]) begin
                n_fail++;
                $display("FAIL scan_%0d: got an=%b seg=%h expected an=%b seg=%h",
                         k, an, seg, exp_an, exp_seg[k/4]);
            end
            step();
        end
        n_tests++;
        if (count !== 16'h1234) begin
            n_fail++;
            $display("FAIL scan_count: got %h expected 1234", count);
        end
    endtask

    task automatic test_blank();
        logic [7:0] exp_seg [4];
        logic [3:0] exp_an;
        for (int pass = 0; pass < 2; pass++) begin
`ifdef LEADING_ZERO_BLANK_EN
            exp_seg = (pass == 0) ? '{8'h07, 8'h00, 8'h00, 8'h00}
                                  : '{8'h3F, 8'h00, 8'h00, 8'h00};
`else
            exp_seg = (pass == 0) ? '{8'h07, 8'h3F, 8'h3F, 8'h3F}
                                  : '{8'h3F, 8'h3F, 8'h3F, 8'h3F};
`endif
            rst_syn = 1'b1;
            step();
            rst_syn  = 1'b0;
            load_val = (pass == 0) ? 16'h0007 : 16'h0000;
            load     = 1'b1;
            step();
            load = 1'b0;
            for (int k = 0; k < 16; k++) step();
            for (int k = 0; k < 16; k++) begin
                exp_an = 4'b0001 << (k / 4);
                n_tests++;
                if (an !== exp_an || seg !== exp_seg[k/4]) begin
                    n_fail++;
                    $display("FAIL blank_%0d_%0d: got an=%b seg=%h expected an=%b seg=%h",
                             pass, k, an, seg, exp_an, exp_seg[k/4]);
                end
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_load_priority();
        test_scan();
        test_blank();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
